pipe_hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage core; sits beside the forwarding unit and sequences PC, IF/ID, ID/EX, EX/MEM and MEM/WB register enables.
- Resolves load-use stalls that forwarding cannot cover.
- Flushes IF/ID on taken branches and jumps resolved in ID.
- Freezes the whole pipeline while a multi-cycle data-memory access is outstanding, with a watchdog timeout and a stall-cycle counter.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 32 +++
 rtl/pipe_hazard_ctrl_if.sv | 44 ++++
 rtl/pipe_hazard_ctrl_sat_cnt.sv | 20 ++
 rtl/pipe_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Build option: HAZ_PERF_CNT_EN enables the stall-cycle counter (see pipe_hazard_ctrl.sv).
package hazard_pkg;

    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } hz_state_e;

    // One bundle for every pipeline-register control line driven by the block.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic pipe_hold;
        logic mem_wb_bubble;
    } hz_ctrl_t;

    // Free-running pipeline: nothing stalled, nothing squashed.
    localparam hz_ctrl_t CTRL_FLOW     = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    // Data memory outstanding: freeze front end, hold ID/EX and EX/MEM, feed NOP into MEM/WB.
    localparam hz_ctrl_t CTRL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    // Load-use: keep PC and IF/ID, inject a NOP into ID/EX.
    localparam hz_ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    // Taken branch / jump: squash the wrong-path fetch in IF/ID.
    localparam hz_ctrl_t CTRL_FLUSH    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the core pipeline and the hazard controller.
// slave = the controller, master = the pipeline (or a testbench driving it).
interface pipe_hazard_ctrl_if
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] IF_ID_RSaddr_i;
    logic [REG_AW-1:0] IF_ID_RTaddr_i;
    logic              ID_uses_rt_i;
    logic [REG_AW-1:0] ID_EX_RTaddr_i;
    logic              ID_EX_MemRead_i;
    logic              branch_taken_i;
    logic              jump_i;
    logic              dmem_req_i;
    logic              dmem_ack_i;
    logic              timeout_clr_i;

    logic              PC_write_o;
    logic              IF_ID_write_o;
    logic              IF_ID_flush_o;
    logic              ID_EX_bubble_o;
    logic              pipe_hold_o;
    logic              MEM_WB_bubble_o;
    logic              timeout_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport slave (
        input  IF_ID_RSaddr_i, IF_ID_RTaddr_i, ID_uses_rt_i, ID_EX_RTaddr_i,
        input  ID_EX_MemRead_i, branch_taken_i, jump_i, dmem_req_i, dmem_ack_i,
        input  timeout_clr_i,
        output PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_bubble_o,
        output pipe_hold_o, MEM_WB_bubble_o, timeout_o, stall_cnt_o
    );

    modport master (
        output IF_ID_RSaddr_i, IF_ID_RTaddr_i, ID_uses_rt_i, ID_EX_RTaddr_i,
        output ID_EX_MemRead_i, branch_taken_i, jump_i, dmem_req_i, dmem_ack_i,
        output timeout_clr_i,
        input  PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_bubble_o,
        input  pipe_hold_o, MEM_WB_bubble_o, timeout_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_cnt.sv
// Generic saturating up-counter: counts enabled cycles, sticks at all-ones.
module hazard_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt
);

    // Count enabled cycles until the all-ones ceiling is reached.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch/jump flush of IF/ID and a
// full-pipeline freeze while a data-memory access is outstanding, with a sticky
// watchdog timeout.
// Build option: define HAZ_PERF_CNT_EN to include the saturating stall-cycle
// counter on stall_cnt_o; without it the output is tied to zero.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | no memory access outstanding; hazards resolved per cycle
// MEM_WAIT | access issued, waiting for ack; wait_cnt counts missed cycles
// TIMEOUT  | watchdog expired; still frozen until ack, timeout_o raised
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pipe_hazard_ctrl_if.slave  bus
);

    localparam int              WW        = $clog2(MAX_WAIT);
    localparam logic [WW-1:0]   WAIT_LAST = WW'(MAX_WAIT - 1);

    hz_state_e         state, state_nxt;
    logic [WW-1:0]     wait_cnt, wait_nxt;
    logic              timeout_q, timeout_set;
    logic              mem_block, load_use;
    hz_ctrl_t          ctrl;

    logic [REG_AW-1:0] rs_id, rt_id, rt_ex;

    assign rs_id = bus.IF_ID_RSaddr_i;
    assign rt_id = bus.IF_ID_RTaddr_i;
    assign rt_ex = bus.ID_EX_RTaddr_i;

    // Outside RUN the request line is not looked at: only ack releases the freeze.
    assign mem_block = (state == RUN) ? (bus.dmem_req_i && !bus.dmem_ack_i)
                                      : !bus.dmem_ack_i;

    // r0 never carries a loaded value, so a load to r0 cannot create a hazard.
    assign load_use = bus.ID_EX_MemRead_i && (rt_ex != '0) &&
                      ((rt_ex == rs_id) || (bus.ID_uses_rt_i && (rt_ex == rt_id)));

    // Prioritised Mealy control; a load-use stall drops the flush because the
    // branch in ID is resolved again on the next cycle.
    always_comb begin
        ctrl = CTRL_FLOW;
        if (!rst_i) begin
            ctrl = CTRL_FLOW;
        end else if (mem_block) begin
            ctrl = CTRL_FREEZE;
        end else if (load_use) begin
            ctrl = CTRL_LOAD_USE;
        end else if (bus.branch_taken_i || bus.jump_i) begin
            ctrl = CTRL_FLUSH;
        end
    end

    // Next-state and watchdog counter for the memory-wait sequencing.
    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        timeout_set = 1'b0;
        case (state)
            RUN: begin
                if (bus.dmem_req_i && !bus.dmem_ack_i) begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = '0;
                end
            end
            MEM_WAIT: begin
                if (bus.dmem_ack_i) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt   = TIMEOUT;
                    timeout_set = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            TIMEOUT: begin
                if (bus.dmem_ack_i) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end
            end
            default: begin
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        endcase
    end

    // State, watchdog count and sticky timeout flag (set beats clear).
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= RUN;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end else if (bus.timeout_clr_i) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign bus.PC_write_o      = ctrl.pc_write;
    assign bus.IF_ID_write_o   = ctrl.if_id_write;
    assign bus.IF_ID_flush_o   = ctrl.if_id_flush;
    assign bus.ID_EX_bubble_o  = ctrl.id_ex_bubble;
    assign bus.pipe_hold_o     = ctrl.pipe_hold;
    assign bus.MEM_WB_bubble_o = ctrl.mem_wb_bubble;
    assign bus.timeout_o       = timeout_q;

`ifdef HAZ_PERF_CNT_EN
    logic stall_cycle;

    // A stall cycle is any cycle in which the PC does not advance.
    assign stall_cycle = !ctrl.pc_write;

    hazard_sat_cnt #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_n (rst_i),
        .en    (stall_cycle),
        .cnt   (bus.stall_cnt_o)
    );
`else
    assign bus.stall_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic, all compared against a transaction-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int AW      = 5;
    localparam int MW      = 16;
    localparam int CW      = 4;
    localparam int CNT_MAX = 15;
`ifdef HAZ_PERF_CNT_EN
    localparam logic [CW-1:0] SAT_EXP = 4'd15;
`else
    localparam logic [CW-1:0] SAT_EXP = 4'd0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_AW(AW), .CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(
        .REG_AW   (AW),
        .MAX_WAIT (MW),
        .CNT_W    (CW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    bit m_busy;     // a memory access is outstanding
    int m_waited;   // cycles spent waiting without ack
    bit m_to;       // sticky timeout flag
    int m_stalls;   // cycles in which the PC did not advance

    task automatic model_reset();
        m_busy = 0; m_waited = 0; m_to = 0; m_stalls = 0;
    endtask

    // {pc_write, if_id_write, flush, id_ex_bubble, hold, mem_wb_bubble}
    function automatic logic [5:0] model_ctrl();
        bit frozen, hazard;
        if (!rst_n) return 6'b110000;
        frozen = m_busy ? !bus.dmem_ack_i : (bus.dmem_req_i && !bus.dmem_ack_i);
        hazard = bus.ID_EX_MemRead_i && (bus.ID_EX_RTaddr_i != 0) &&
                 ((bus.ID_EX_RTaddr_i == bus.IF_ID_RSaddr_i) ||
                  (bus.ID_uses_rt_i && (bus.ID_EX_RTaddr_i == bus.IF_ID_RTaddr_i)));
        if (frozen) return 6'b000011;
        if (hazard) return 6'b000100;
        if (bus.branch_taken_i || bus.jump_i) return 6'b111000;
        return 6'b110000;
    endfunction

    function automatic logic [CW-1:0] exp_cnt();
`ifdef HAZ_PERF_CNT_EN
        return CW'(m_stalls);
`else
        return '0;
`endif
    endfunction

    function automatic logic [6+CW:0] exp_vec();
        return {model_ctrl(), m_to, exp_cnt()};
    endfunction

    function automatic logic [6+CW:0] obs_vec();
        return {bus.PC_write_o, bus.IF_ID_write_o, bus.IF_ID_flush_o, bus.ID_EX_bubble_o,
                bus.pipe_hold_o, bus.MEM_WB_bubble_o, bus.timeout_o, bus.stall_cnt_o};
    endfunction

    // Advance the model by one clock using this cycle's inputs.
    task automatic model_step();
        bit stalled, set;
        if (!rst_n) return;
        stalled = !model_ctrl()[5];
        set = 0;
        if (!m_busy) begin
            if (bus.dmem_req_i && !bus.dmem_ack_i) begin
                m_busy = 1; m_waited = 0;
            end
        end else if (bus.dmem_ack_i) begin
            m_busy = 0;
        end else begin
            m_waited++;
            if (m_waited == MW) set = 1;
        end
        if (set) m_to = 1;
        else if (bus.timeout_clr_i) m_to = 0;
        if (stalled && m_stalls < CNT_MAX) m_stalls++;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input int rs, input int rtid, input bit ur, input int rtex,
                          input bit mr, input bit br, input bit jp,
                          input bit rq, input bit ak, input bit cl);
        bus.IF_ID_RSaddr_i  = AW'(rs);
        bus.IF_ID_RTaddr_i  = AW'(rtid);
        bus.ID_uses_rt_i    = ur;
        bus.ID_EX_RTaddr_i  = AW'(rtex);
        bus.ID_EX_MemRead_i = mr;
        bus.branch_taken_i  = br;
        bus.jump_i          = jp;
        bus.dmem_req_i      = rq;
        bus.dmem_ack_i      = ak;
        bus.timeout_clr_i   = cl;
    endtask

    task automatic idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Clock edge: model follows the DUT, then return to the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b1;
        set_in(5, 0, 0, 5, 1, 1, 0, 1, 0, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++; $display("FAIL reset_outputs: got %b required %b", obs_vec(), exp_vec());
        end
        checks++;
        if ({bus.PC_write_o, bus.IF_ID_write_o, bus.pipe_hold_o, bus.timeout_o} !== 4'b1100) begin
            failures++; $display("FAIL reset_const: got %b required 1100",
                {bus.PC_write_o, bus.IF_ID_write_o, bus.pipe_hold_o, bus.timeout_o});
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        #1;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++; $display("FAIL reset_release: got %b required %b", obs_vec(), exp_vec());
        end
        tick();
    endtask

    task automatic test_load_use();
        // rs match, rt match with/without use flag, r0 and no-load cases
        int rs_t[6]  = '{5, 0, 3, 3, 9, 4};
        int rtd_t[6] = '{1, 0, 7, 7, 9, 4};
        bit ur_t[6]  = '{0, 0, 0, 1, 1, 1};
        int rte_t[6] = '{5, 0, 7, 7, 9, 4};
        bit mr_t[6]  = '{1, 1, 1, 1, 0, 1};
        for (int i = 0; i < 6; i++) begin
            set_in(rs_t[i], rtd_t[i], ur_t[i], rte_t[i], mr_t[i], 0, 0, 0, 0, 0);
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL load_use case %0d: got %b required %b", i, obs_vec(), exp_vec());
            end
            tick();
            idle();
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL load_use_after case %0d: got %b required %b", i, obs_vec(), exp_vec());
            end
        end
        set_in(5, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if ({bus.PC_write_o, bus.IF_ID_write_o, bus.ID_EX_bubble_o} !== 3'b001) begin
            failures++; $display("FAIL load_use_const: got %b required 001",
                {bus.PC_write_o, bus.IF_ID_write_o, bus.ID_EX_bubble_o});
        end
        tick();
        idle();
    endtask

    task automatic test_branch();
        bit br_t[4] = '{1, 0, 1, 0};
        bit jp_t[4] = '{0, 1, 0, 1};
        bit lu_t[4] = '{0, 0, 1, 1};
        for (int i = 0; i < 4; i++) begin
            set_in(6, 0, 0, 6, lu_t[i], br_t[i], jp_t[i], 0, 0, 0);
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL branch case %0d: got %b required %b", i, obs_vec(), exp_vec());
            end
            tick();
        end
        idle();
    endtask

    task automatic test_mem_wait();
        // ack on cycle 3, request held
        for (int i = 0; i <= 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, i == 3, 0);
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL mem_wait cycle %0d: got %b required %b", i, obs_vec(), exp_vec());
            end
            tick();
        end
        // request with same-cycle ack, plus a branch that must still flush
        set_in(0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
        #1;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++; $display("FAIL mem_same_ack: got %b required %b", obs_vec(), exp_vec());
        end
        tick();
        // request drops while waiting: still frozen until ack
        for (int i = 0; i <= 4; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, i == 0, i == 4, 0);
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL mem_req_drop cycle %0d: got %b required %b", i, obs_vec(), exp_vec());
            end
            tick();
        end
        idle();
    endtask

    task automatic test_timeout();
        // no ack until cycle 20; clear pulsed on the very cycle the timeout sets
        for (int i = 0; i <= 20; i++) begin
            set_in(2, 0, 0, 2, i == 5, 0, 0, i == 0, i == 20, i == 16);
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL timeout cycle %0d: got %b required %b", i, obs_vec(), exp_vec());
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if ({bus.timeout_o, bus.PC_write_o} !== 2'b11) begin
            failures++; $display("FAIL timeout_sticky: got %b required 11", {bus.timeout_o, bus.PC_write_o});
        end
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        idle();
        #1;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++; $display("FAIL timeout_clear: got %b required %b", obs_vec(), exp_vec());
        end
        checks++;
        if (bus.timeout_o !== 1'b0) begin
            failures++; $display("FAIL timeout_clear_const: got %b required 0", bus.timeout_o);
        end
        tick();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        #1;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++; $display("FAIL async_pre: got %b required %b", obs_vec(), exp_vec());
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++; $display("FAIL async_reset: got %b required %b", obs_vec(), exp_vec());
        end
        checks++;
        if ({bus.pipe_hold_o, bus.PC_write_o, bus.stall_cnt_o} !== {2'b01, 4'd0}) begin
            failures++; $display("FAIL async_reset_const: got %b required 010000",
                {bus.pipe_hold_o, bus.PC_write_o, bus.stall_cnt_o});
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        #1;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++; $display("FAIL async_release: got %b required %b", obs_vec(), exp_vec());
        end
        tick();
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            set_in(3, 0, 0, 3, 1, 0, 0, 0, 0, 0);
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL saturation cycle %0d: got %b required %b", i, obs_vec(), exp_vec());
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (bus.stall_cnt_o !== SAT_EXP) begin
            failures++; $display("FAIL saturation_hold: got %0d required %0d", bus.stall_cnt_o, SAT_EXP);
        end
        tick();
    endtask

    task automatic test_random();
        int ack_pct;
        for (int i = 0; i < 600; i++) begin
            ack_pct = (i < 350) ? 40 : 3;
            set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
                   $urandom_range(0, 99) < 30, $urandom_range(0, 99) < ack_pct,
                   $urandom_range(0, 99) < 5);
            #1;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++; $display("FAIL random cycle %0d: got %b required %b", i, obs_vec(), exp_vec());
            end
            tick();
        end
        idle();
    endtask

    initial begin
        model_reset();
        idle();
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_async_reset();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
